ling_serial_subtractor: RTL and testbench
=========================================

Name: ling_serial_subtractor

Overview:
- Multi-precision serial subtractor, the inverse-operation companion to the team's 8-bit sparse Ling adder.
- Consumes two operands as WORDS beats of 8 bits each, least-significant word first, and streams out the difference a - b one beat per cycle.
- Each beat is computed as a + ~b + c with an 8-bit Ling sparse-tree datapath: 2-bit H1 / P1 groups, a 4-group H2 stage and a sparse-2 sum stage.
- The inter-word carry is registered. Sits between operand-stream sources and the result consumer with valid/ready flow control on both sides.

Parameters:
- WORDS, 4, number of 8-bit beats per operand (>=1); total operand width 8*WORDS.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  8  minuend word.
- in_b  input  8  subtrahend word.
- out_valid  output  1  difference beat valid.
- out_ready  input  1  consumer accepts a beat.
- out_diff  output  8  difference word.
- out_last  output  1  marks the final beat (word WORDS-1) of an operation.
- out_borrow  output  1  final borrow (1 when a < b unsigned); meaningful only when out_last=1, otherwise 0.
- out_zero  output  1  whole 8*WORDS result is zero; meaningful only when out_last=1, otherwise 0.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_diff=0, out_last=0, out_borrow=0, out_zero=0. Beat counter=0, carry register=1, zero accumulator=1, FSM=IDLE.
- Handshake:
  - Input beat accepted when in_valid && in_ready.
  - Output beat consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is a single output register with no skid buffer, giving full throughput of 1 beat/cycle.
- Latency: an accepted beat appears on out_diff on the next cycle.
- FSM (two states):
  - IDLE (counter=0): carry=1 applied to the word-0 computation. Accepting a beat moves to RUN, or stays in IDLE when WORDS=1 because that beat is also the last.
  - RUN: counter increments per accepted beat. When the accepted beat has counter=WORDS-1, the counter wraps to 0, carry resets to 1, the zero accumulator resets to 1, and the FSM returns to IDLE.
- Per accepted beat:
  - {c_out, d} = in_a + ~in_b + c, 9-bit result.
  - out_diff <= d.
  - Carry register <= c_out.
  - Zero accumulator <= zacc && (d==0).
  - out_last <= (counter==WORDS-1).
  - On the last beat: out_borrow <= ~c_out and out_zero <= zacc && (d==0). On other beats both are driven 0.
- Output stall: while out_valid=1 and out_ready=0, all out_* signals hold and no input is accepted.
- Output without new input: if the output is consumed and no input arrives, out_valid <= 0. out_diff holds its last value (don't-care).
- Idle input: in_valid=0 mid-operation leaves counter, carry and accumulator unchanged. There is no timeout.
- Reset mid-operation: the operation is discarded with no partial completion, and the next accepted beat is treated as word 0.
- Counter width: max(1, clog2(WORDS)).

Optional Feature:
- Macro LING_ADDSUB_MODE_EN.
- Defined:
  - Adds input port op_sub (1 bit), sampled only on the word-0 accepted beat and latched for the whole operation.
  - op_sub=1 behaves exactly as the base subtractor.
  - op_sub=0 computes a + b: b is not inverted and the initial carry is 0.
  - In add mode out_borrow reports the final carry-out (unsigned overflow) instead of the borrow.
  - op_sub on beats other than word 0 is ignored.
- Not defined: the port is absent and the block always subtracts.

Test Plan:
- WORDS=4, a=0x00000005, b=0x00000003, beats LSB first -> out_diff 02,00,00,00; out_last only on beat 4; out_borrow=0, out_zero=0; each beat on the cycle after acceptance.
- a=0x00000000, b=0x00000001 -> out_diff FF,FF,FF,FF; final out_borrow=1, out_zero=0.
- a=b=0x12345678 -> out_diff 00,00,00,00; final out_zero=1, out_borrow=0. Carry chain crossing words: a=0x00000100, b=0x00000001 -> FF,00,00,00.
- Back-to-back ops with out_ready held low 3 cycles after beat 2 -> in_ready=0 and out_* stable during the stall; no beat lost or duplicated; the second op starts with carry=1 (verify 0x00000001-0x00000001 -> zero=1).
- rst_n pulsed low asynchronously (mid-cycle) after beat 2 of 4 -> outputs clear immediately; a following full op 0x0000000A-0x00000004 -> 06,00,00,00, borrow=0.
- With LING_ADDSUB_MODE_EN, op_sub=0: 0xFFFFFFFF + 0x00000001 -> 00,00,00,00, out_borrow(carry)=1, out_zero=1. Then op_sub=0 on word 0 only with op_sub toggling on later beats -> result unaffected.

Source files
------------

// File: rtl/ling_serial_subtractor.sv
// Multi-word serial subtractor: streams a - b one 8-bit beat per cycle, LS word first, over a Ling sparse-tree datapath.
// Optional LING_ADDSUB_MODE_EN adds op_sub (latched on word 0) to select a + b instead.
//
// state | meaning
// IDLE  | waiting for word 0; carry-in forced to the initial value
// RUN   | mid-operation; carry-in taken from the inter-word carry register
module ling_serial_subtractor #(
  parameter int WORDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
`ifdef LING_ADDSUB_MODE_EN
  input  logic       op_sub,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_diff,
  output logic       out_last,
  output logic       out_borrow,
  output logic       out_zero
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          carry, carry_nx, zacc, zacc_nx;
  logic          valid_nx, last_nx, borrow_nx, zero_nx;
  logic [7:0]    diff_nx, bb, d;
  logic [8:0]    sum;
  logic          accept, sub_mode, cin, is_last, dz;
`ifdef LING_ADDSUB_MODE_EN
  logic          sub_r, sub_nx;
`endif

  // Ling pseudo-carries H = g | t_prev & H_prev; real carry into a group is t_prev & H.
  function automatic logic [8:0] ling8(input logic [7:0] a, input logic [7:0] b, input logic ci);
    logic [7:0] g, t, x, s;
    logic [3:0] h1, i1, hg, cg;
    logic       h2_lo, i2_lo, h2_hi, i2_hi;
    g = a & b;
    t = a | b;
    x = a ^ b;
    h1[0] = g[1] | g[0];
    h1[1] = g[3] | g[2];
    h1[2] = g[5] | g[4];
    h1[3] = g[7] | g[6];
    i1[0] = t[0] & ci;
    i1[1] = t[2] & t[1];
    i1[2] = t[4] & t[3];
    i1[3] = t[6] & t[5];
    h2_lo = h1[1] | (i1[1] & h1[0]);
    i2_lo = i1[1] & i1[0];
    h2_hi = h1[3] | (i1[3] & h1[2]);
    i2_hi = i1[3] & i1[2];
    hg[0] = h1[0] | (i1[0] & ci);
    hg[1] = h2_lo | (i2_lo & ci);
    hg[2] = h1[2] | (i1[2] & hg[1]);
    hg[3] = h2_hi | (i2_hi & hg[1]);
    cg[0] = ci;
    cg[1] = t[1] & hg[0];
    cg[2] = t[3] & hg[1];
    cg[3] = t[5] & hg[2];
    for (int k = 0; k < 4; k++) begin
      s[2*k]   = x[2*k] ^ cg[k];
      s[2*k+1] = x[2*k+1] ^ (g[2*k] | (t[2*k] & cg[k]));
    end
    return {t[7] & hg[3], s};
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

`ifdef LING_ADDSUB_MODE_EN
  assign sub_mode = (state == IDLE) ? op_sub : sub_r;
`else
  assign sub_mode = 1'b1;
`endif

  // Word 0 starts with carry 1 for subtract (two's complement) and 0 for add.
  assign cin     = (state == IDLE) ? sub_mode : carry;
  assign bb      = sub_mode ? ~in_b : in_b;
  assign sum     = ling8(in_a, bb, cin);
  assign d       = sum[7:0];
  assign is_last = (cnt == LAST);
  assign dz      = zacc && (d == 8'h00);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    carry_nx  = carry;
    zacc_nx   = zacc;
    valid_nx  = out_valid;
    diff_nx   = out_diff;
    last_nx   = out_last;
    borrow_nx = out_borrow;
    zero_nx   = out_zero;
`ifdef LING_ADDSUB_MODE_EN
    sub_nx    = sub_r;
    if (accept && state == IDLE) sub_nx = op_sub;
`endif
    if (accept) begin
      valid_nx  = 1'b1;
      diff_nx   = d;
      last_nx   = is_last;
      borrow_nx = is_last && (sub_mode ? ~sum[8] : sum[8]);
      zero_nx   = is_last && dz;
      if (is_last) begin
        cnt_nx   = '0;
        carry_nx = 1'b1;
        zacc_nx  = 1'b1;
        state_nx = IDLE;
      end else begin
        cnt_nx   = cnt + CW'(1);
        carry_nx = sum[8];
        zacc_nx  = dz;
        state_nx = RUN;
      end
    end else if (out_ready) begin
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      carry      <= 1'b1;
      zacc       <= 1'b1;
      out_valid  <= 1'b0;
      out_diff   <= 8'h00;
      out_last   <= 1'b0;
      out_borrow <= 1'b0;
      out_zero   <= 1'b0;
`ifdef LING_ADDSUB_MODE_EN
      sub_r      <= 1'b1;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      carry      <= carry_nx;
      zacc       <= zacc_nx;
      out_valid  <= valid_nx;
      out_diff   <= diff_nx;
      out_last   <= last_nx;
      out_borrow <= borrow_nx;
      out_zero   <= zero_nx;
`ifdef LING_ADDSUB_MODE_EN
      sub_r      <= sub_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ling_serial_subtractor.sv
// Directed bench for ling_serial_subtractor (WORDS=4): vector table plus stall, reset and add-mode sequences.
module tb_ling_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_diff;
  logic       out_last;
  logic       out_borrow;
  logic       out_zero;
`ifdef LING_ADDSUB_MODE_EN
  logic       op_sub = 1'b1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
    logic        z;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  ling_serial_subtractor #(.WORDS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
`ifdef LING_ADDSUB_MODE_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
    .out_last(out_last), .out_borrow(out_borrow), .out_zero(out_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ed,
                      input logic el, input logic eb, input logic ez);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    #1 chk("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_diff", 32'(out_diff), 32'(ed));
    chk("out_last", 32'(out_last), 32'(el));
    chk("out_borrow", 32'(out_borrow), 32'(eb));
    chk("out_zero", 32'(out_zero), 32'(ez));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                        input logic eb, input logic ez);
    for (int i = 0; i < 4; i++)
      beat(a[8*i +: 8], b[8*i +: 8], ed[8*i +: 8], i == 3, (i == 3) && eb, (i == 3) && ez);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1 chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{a: 32'h00000005, b: 32'h00000003, d: 32'h00000002, bo: 1'b0, z: 1'b0};
    vecs[1] = '{a: 32'h00000000, b: 32'h00000001, d: 32'hFFFFFFFF, bo: 1'b1, z: 1'b0};
    vecs[2] = '{a: 32'h12345678, b: 32'h12345678, d: 32'h00000000, bo: 1'b0, z: 1'b1};
    vecs[3] = '{a: 32'h00000100, b: 32'h00000001, d: 32'h000000FF, bo: 1'b0, z: 1'b0};
    vecs[4] = '{a: 32'h80000000, b: 32'h7FFFFFFF, d: 32'h00000001, bo: 1'b0, z: 1'b0};
    vecs[5] = '{a: 32'h00001234, b: 32'hABCD0000, d: 32'h54331234, bo: 1'b1, z: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_diff", 32'(out_diff), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_borrow", 32'(out_borrow), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++)
      run_op(vecs[v].a, vecs[v].b, vecs[v].d, vecs[v].bo, vecs[v].z);
    go_idle();

    // stall after beat 2: 0x40302010 - 0x04030201 = 0x3C2D1E0F, then back-to-back 1-1
    beat(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
    beat(8'h20, 8'h02, 8'h1E, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_a = 8'h30;
    in_b = 8'h03;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_diff", 32'(out_diff), 32'h1E);
      chk("stall_out_last", 32'(out_last), 32'd0);
    end
    out_ready = 1'b1;
    beat(8'h30, 8'h03, 8'h2D, 1'b0, 1'b0, 1'b0);
    beat(8'h40, 8'h04, 8'h3C, 1'b1, 1'b0, 1'b0);
    run_op(32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 1'b1);
    go_idle();

    // asynchronous reset mid-operation
    beat(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
    beat(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_diff", 32'(out_diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000000A, 32'h00000004, 32'h00000006, 1'b0, 1'b0);
    go_idle();

`ifdef LING_ADDSUB_MODE_EN
    op_sub = 1'b0;
    run_op(32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1);
    // 0x01020304 + 0x10203040 = 0x11223344; op_sub toggles after word 0
    begin
      logic [31:0] aa, bv, ev;
      aa = 32'h01020304;
      bv = 32'h10203040;
      ev = 32'h11223344;
      for (int i = 0; i < 4; i++) begin
        op_sub = (i == 0) ? 1'b0 : ((i % 2) == 1);
        beat(aa[8*i +: 8], bv[8*i +: 8], ev[8*i +: 8], i == 3, 1'b0, 1'b0);
      end
    end
    op_sub = 1'b1;
    run_op(32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0);
    go_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
